// File: rtl/riscv_fetch_decode_pipe.sv
// Two-stage RV32I front end: F reads the instruction memory at the fetch PC,
// D holds the decoded instruction and offers it downstream with valid/ready.
// Fetch stops once the PC runs past the end of memory; a redirect flushes
// both stages and restarts fetch at a new PC.
module riscv_fetch_decode_pipe #(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          redirect_valid,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XLEN-1:0]               out_pc,
    output logic [31:0]                   out_instr,
    output logic [6:0]                    opcode,
    output logic [4:0]                    rd,
    output logic [2:0]                    funct3,
    output logic [4:0]                    rs1,
    output logic [4:0]                    rs2,
    output logic [6:0]                    funct7,
    output logic [XLEN-1:0]               imm,
    output logic                          illegal,
    output logic                          halted
);

    localparam int              AW       = $clog2(IMEM_DEPTH);
    localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_DEPTH * 4);

    logic [31:0]     r_mem [IMEM_DEPTH];

    logic [XLEN-1:0] r_pc;
    logic            r_misalign_pend;   // next fetch is the first after a misaligned redirect

    logic            r_f_valid;
    logic [XLEN-1:0] r_f_pc;
    logic [31:0]     r_f_instr;
    logic            r_f_misalign;

    logic            r_d_valid;
    logic [XLEN-1:0] r_d_pc;
    logic [31:0]     r_d_instr;
    logic [XLEN-1:0] r_d_imm;
    logic            r_d_illegal;

    logic            w_d_take;
    logic            w_f_load;
    logic            w_halted;
    logic            w_fetch;
    logic [AW-1:0]   w_fetch_idx;
    logic [31:0]     w_mem_word;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_f_imm;
    logic            w_legal_op;
    logic            w_f_illegal;

    // D can accept when empty or when its content leaves this cycle; F refills on the same terms
    assign w_d_take    = !r_d_valid || out_ready;
    assign w_f_load    = !r_f_valid || w_d_take;
    assign w_halted    = (r_pc >= PC_LIMIT);
    assign w_fetch     = w_f_load && !w_halted;
    assign w_fetch_idx = r_pc[AW+1:2];
    assign w_mem_word  = r_mem[w_fetch_idx];

    // Instruction memory write port; contents survive reset, a same-cycle fetch sees the old word
    always_ff @(posedge clk) begin
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Immediate and legality decode of the word sitting in F, captured into D alongside it
    always_comb begin
        w_imm32    = '0;
        w_legal_op = 1'b0;
        case (r_f_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: begin
                w_imm32    = {{20{r_f_instr[31]}}, r_f_instr[31:20]};
                w_legal_op = 1'b1;
            end
            7'b0100011: begin
                w_imm32    = {{20{r_f_instr[31]}}, r_f_instr[31:25], r_f_instr[11:7]};
                w_legal_op = 1'b1;
            end
            7'b1100011: begin
                w_imm32    = {{19{r_f_instr[31]}}, r_f_instr[31], r_f_instr[7],
                              r_f_instr[30:25], r_f_instr[11:8], 1'b0};
                w_legal_op = 1'b1;
            end
            7'b0110111, 7'b0010111: begin
                w_imm32    = {r_f_instr[31:12], 12'b0};
                w_legal_op = 1'b1;
            end
            7'b1101111: begin
                w_imm32    = {{11{r_f_instr[31]}}, r_f_instr[31], r_f_instr[19:12],
                              r_f_instr[20], r_f_instr[30:21], 1'b0};
                w_legal_op = 1'b1;
            end
            7'b0110011, 7'b1110011: begin
                w_legal_op = 1'b1;
            end
            default: begin
                w_legal_op = 1'b0;
            end
        endcase
        w_f_imm     = XLEN'($signed(w_imm32));
        w_f_illegal = !w_legal_op || (r_f_instr[1:0] != 2'b11) || r_f_misalign;
    end

    // Fetch stage and PC; a redirect wins over any advance on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc            <= RESET_PC;
            r_misalign_pend <= 1'b0;
            r_f_valid       <= 1'b0;
            r_f_pc          <= '0;
            r_f_instr       <= '0;
            r_f_misalign    <= 1'b0;
        end else if (redirect_valid) begin
            r_pc            <= {redirect_pc[XLEN-1:2], 2'b00};
            r_misalign_pend <= |redirect_pc[1:0];
            r_f_valid       <= 1'b0;
        end else if (w_f_load) begin
            r_f_valid <= w_fetch;
            if (w_fetch) begin
                r_f_pc          <= r_pc;
                r_f_instr       <= w_mem_word;
                r_f_misalign    <= r_misalign_pend;
                r_pc            <= r_pc + XLEN'(4);
                r_misalign_pend <= 1'b0;
            end
        end
    end

    // Decode stage register; holds everything stable while downstream stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_d_valid   <= 1'b0;
            r_d_pc      <= '0;
            r_d_instr   <= '0;
            r_d_imm     <= '0;
            r_d_illegal <= 1'b0;
        end else if (redirect_valid) begin
            r_d_valid <= 1'b0;
        end else if (w_d_take) begin
            r_d_valid <= r_f_valid;
            if (r_f_valid) begin
                r_d_pc      <= r_f_pc;
                r_d_instr   <= r_f_instr;
                r_d_imm     <= w_f_imm;
                r_d_illegal <= w_f_illegal;
            end
        end
    end

    assign out_valid = r_d_valid;
    assign out_pc    = r_d_pc;
    assign out_instr = r_d_instr;
    assign opcode    = r_d_instr[6:0];
    assign rd        = r_d_instr[11:7];
    assign funct3    = r_d_instr[14:12];
    assign rs1       = r_d_instr[19:15];
    assign rs2       = r_d_instr[24:20];
    assign funct7    = r_d_instr[31:25];
    assign imm       = r_d_imm;
    assign illegal   = r_d_illegal;
    assign halted    = w_halted;

endmodule

// File: tb/tb_riscv_fetch_decode_pipe.sv
// Bench for riscv_fetch_decode_pipe: a stream model predicts which PC must be
// presented next and what its decode must be; directed steps pin latency,
// stall, halt, redirect and reset behaviour with literal values.
module tb_riscv_fetch_decode_pipe;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 16;
    localparam logic [31:0] LIMIT = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [31:0] load_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        illegal;
    logic        halted;

    always #5 clk = ~clk;

    riscv_fetch_decode_pipe #(.XLEN(XLEN), .IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset_n(reset_n),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2), .funct7(funct7),
        .imm(imm), .illegal(illegal), .halted(halted)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [31:0] model_mem [DEPTH];

    function automatic logic [31:0] sext(input logic [31:0] v, input int n);
        if (v[n-1]) return v - (32'd1 << n);
        return v;
    endfunction

    function automatic logic [31:0] m_imm(input logic [31:0] w);
        logic [6:0] op;
        op = w[6:0];
        if (op inside {7'h13, 7'h03, 7'h67}) return sext(w >> 20, 12);
        if (op == 7'h23) return sext(((w >> 25) << 5) | ((w >> 7) & 32'd31), 12);
        if (op == 7'h63) return sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                                     (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
        if (op inside {7'h37, 7'h17}) return w & 32'hFFFF_F000;
        if (op == 7'h6F) return sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                                     (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
        return 32'h0;
    endfunction

    function automatic logic m_illegal(input logic [31:0] w);
        logic [6:0] legal_ops [10];
        logic       ok;
        legal_ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h73};
        ok = 1'b0;
        foreach (legal_ops[k]) if (w[6:0] == legal_ops[k]) ok = 1'b1;
        return !ok || (w[1:0] != 2'b11);
    endfunction

    // Next PC the stream must present, whether it is the first after a misaligned redirect
    logic [31:0] m_next = 32'h0;
    bit          m_bad  = 1'b0;
    int          n_xfer = 0;

    // Compare process: inputs change just after posedge, so negedge sees settled values
    always @(negedge clk) begin
        logic [31:0] w;
        if (!reset_n) begin
            check("reset_valid", out_valid, 1'b0);
            m_next = 32'h0;
            m_bad  = 1'b0;
        end else begin
            if (out_valid) begin
                w = model_mem[m_next[5:2]];
                check("stream_pc", out_pc, m_next);
                check("stream_pc_range", out_pc < LIMIT, 1'b1);
                check("stream_instr", out_instr, w);
                check("stream_fields", {opcode, rd, funct3, rs1, rs2, funct7},
                      {w[6:0], w[11:7], w[14:12], w[19:15], w[24:20], w[31:25]});
                check("stream_imm", imm, m_imm(w));
                check("stream_illegal", illegal, m_illegal(w) | m_bad);
            end
            if (redirect_valid) begin
                m_next = redirect_pc & ~32'd3;
                m_bad  = |redirect_pc[1:0];
            end else if (out_valid && out_ready) begin
                m_next = m_next + 4;
                m_bad  = 1'b0;
                n_xfer++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        n_xfer  = 0;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [31:0] prog [DEPTH];
        prog = '{32'h0020_0093, 32'h0020_81B3, 32'hFE00_0FA3, 32'hFE00_0EE3,
                 32'h8000_00EF, 32'h1234_5037, 32'h0000_0000, 32'h0010_0073,
                 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013,
                 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013};

        reset_n = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_fields", {out_instr, imm, illegal}, '0);

        // Load the program while held in reset
        step();
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
            step();
            model_mem[i] = prog[i];
        end
        load_en = 1'b0;

        // Latency, field decode and immediates
        release_reset();
        step();
        check("lat_cycle1_valid", out_valid, 1'b0);
        step();
        check("addi_valid", out_valid, 1'b1);
        check("addi_pc", out_pc, 32'h0);
        check("addi_op_rd", {opcode, rd}, {7'h13, 5'd1});
        check("addi_imm", imm, 32'h2);
        step();
        check("add_pc", out_pc, 32'h4);
        check("add_fields", {opcode, rs1, rs2}, {7'h33, 5'd1, 5'd2});
        check("add_imm", imm, 32'h0);
        step(); check("sb_imm", imm, 32'hFFFF_FFFF);
        step(); check("beq_imm", imm, 32'hFFFF_FFFC);
        step(); check("jal_imm", imm, 32'hFFF0_0000);
        step(); check("lui_imm", imm, 32'h1234_5000);
        step(); check("zero_pc", out_pc, 32'd24); check("zero_illegal", illegal, 1'b1);
        step(); check("ebreak_illegal", illegal, 1'b0);

        // End of memory: fetch PC reaches 64 on the 16th edge after release
        repeat (6) step();
        check("halt_before_end", halted, 1'b0);
        step();
        check("halt_at_end", halted, 1'b1);
        step();
        check("last_pc", {out_valid, out_pc}, {1'b1, 32'd60});
        step();
        check("drained_valid", out_valid, 1'b0);
        repeat (2) step();
        check("drained_still", out_valid, 1'b0);
        check("drained_count", n_xfer, 16);

        // Redirect out of halt
        redirect_valid = 1'b1; redirect_pc = 32'h4;
        step();
        redirect_valid = 1'b0;
        check("redir_unhalt", halted, 1'b0);
        check("redir_flush", out_valid, 1'b0);
        step();
        check("redir_lat1", out_valid, 1'b0);
        step();
        check("redir_first", {out_valid, out_pc}, {1'b1, 32'h4});

        // Misaligned redirect
        redirect_valid = 1'b1; redirect_pc = 32'h6;
        step();
        redirect_valid = 1'b0;
        repeat (2) step();
        check("misal_pc", out_pc, 32'h4);
        check("misal_illegal", illegal, 1'b1);
        step();
        check("misal_next_ok", {out_pc, illegal}, {32'h8, 1'b0});

        // Redirect during an accepted transfer drops the in-flight fetch
        check("pre_redir_valid", out_valid, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("xfer_redir_flush", out_valid, 1'b0);
        repeat (2) step();
        check("xfer_redir_pc", {out_valid, out_pc}, {1'b1, 32'h20});

        // Asynchronous reset mid-stream
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 1'b0);
        check("async_rst_pc", out_pc, 32'h0);
        check("async_rst_imm", imm, 32'h0);

        // Redirect while in reset is ignored
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        step(); step();
        redirect_valid = 1'b0;

        // Back-pressure: hold the first instruction for three edges
        release_reset();
        step(); step();
        check("stall_first", {out_valid, out_pc}, {1'b1, 32'h0});
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_pc", out_pc, 32'h0);
            check("stall_hold_instr", out_instr, 32'h0020_0093);
        end
        out_ready = 1'b1;
        step(); check("stall_after_pc4", out_pc, 32'h4);
        step(); check("stall_after_pc8", out_pc, 32'h8);
        repeat (20) step();
        check("stall_count", n_xfer, 16);
        check("stall_halted", {out_valid, halted}, {1'b0, 1'b1});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
